// File: rtl/peripheral_arb_pkg.sv
// Shared types, address map and decode helper for the two-master peripheral arbiter.
package peripheral_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    TGT_REG = 2'd0,
    TGT_MEM = 2'd1,
    TGT_ERR = 2'd2
  } target_t;

  localparam logic [31:0] REG_BASE  = 32'd0;
  localparam logic [31:0] REG_LIMIT = 32'd15;
  localparam logic [31:0] MEM_BASE  = 32'd1024;
  localparam logic [31:0] MEM_LIMIT = 32'd2047;

  // Offset form keeps the check valid for a zero base: addresses below base wrap high.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] limit);
    return (addr - base) <= (limit - base);
  endfunction

  function automatic target_t decode_target(input logic [31:0] addr);
    target_t tgt;
    tgt = TGT_ERR;
    if (in_window(addr, REG_BASE, REG_LIMIT)) tgt = TGT_REG;
    else if (in_window(addr, MEM_BASE, MEM_LIMIT)) tgt = TGT_MEM;
    return tgt;
  endfunction

endpackage

// File: rtl/peripheral_arb_rr.sv
// Two-way round-robin grant; the last-granted pointer resets to m1 so m0 wins the first tie.
module peripheral_arb_rr (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant,
  output logic last_grant
);

  logic last_q;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = ~last_q;
    else if (req1)    grant = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_q <= 1'b1;
    else if (update) last_q <= grant;
  end

  assign last_grant = last_q;

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Two-master front end for peripheral_top: address decode, round-robin sharing, strobe/wait FSM.
// Optional read-wait timeout enabled by defining PERIPH_ARB_TIMEOUT_EN.
module peripheral_bus_arbiter
  import peripheral_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        reg_read,
  output logic        reg_write,
  output logic [1:0]  reg_address,
  output logic [31:0] reg_data_in,
  input  logic        reg_read_valid,
  input  logic [31:0] reg_data_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_data_out,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a master holds req (with stable command) until its one-cycle ack;
  // req high at an IDLE edge starts a new transaction, so it must drop or change after ack.

  arb_state_t  state_q, state_d;
  target_t     tgt_q;
  logic        owner_q;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        any_req;
  logic        grant;
  logic        last_grant;
  logic        sel_valid;
  logic [31:0] sel_data;
  logic [31:0] cmd_address;
  logic        timeout;

  assign any_req     = m0_req | m1_req;
  assign cmd_address = grant ? m1_address : m0_address;

  peripheral_arb_rr u_rr (
    .clk        (clk),
    .reset      (reset),
    .req0       (m0_req),
    .req1       (m1_req),
    .update     ((state_q == ST_IDLE) && any_req),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // Only the port the latched command targets can complete a read.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 32'd0;
    case (tgt_q)
      TGT_REG: begin sel_valid = reg_read_valid; sel_data = reg_data_out; end
      TGT_MEM: begin sel_valid = mem_read_valid; sel_data = mem_data_out; end
      default: ;
    endcase
  end

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt_q <= 8'd0;
    else if (state_q == ST_ISSUE) wait_cnt_q <= 8'd0;
    else if (state_q == ST_WAIT)  wait_cnt_q <= wait_cnt_q + 8'd1;
  end

  assign timeout = (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (tgt_q == TGT_ERR || wr_q || sel_valid) state_d = ST_DONE;
        else                                       state_d = ST_WAIT;
      end
      ST_WAIT:  if (sel_valid || timeout) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch and response capture; a valid in the timeout cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_q   <= TGT_ERR;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (any_req) begin
          owner_q <= grant;
          wr_q    <= grant ? m1_write : m0_write;
          wdata_q <= grant ? m1_wdata : m0_wdata;
          addr_q  <= cmd_address[9:2];
          tgt_q   <= decode_target(cmd_address);
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
        end
        ST_ISSUE: begin
          if (tgt_q == TGT_ERR) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end else if (!wr_q && sel_valid) begin
            rdata_q <= sel_data;
          end
        end
        ST_WAIT: begin
          if (sel_valid) begin
            rdata_q <= sel_data;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_address = 2'd0;
    mem_address = 8'd0;
    m0_ack      = 1'b0;
    m0_err      = 1'b0;
    m0_rdata    = 32'd0;
    m1_ack      = 1'b0;
    m1_err      = 1'b0;
    m1_rdata    = 32'd0;
    if (state_q == ST_ISSUE) begin
      case (tgt_q)
        TGT_REG: begin reg_write = wr_q; reg_read = !wr_q; end
        TGT_MEM: begin mem_write = wr_q; mem_read = !wr_q; end
        default: ;
      endcase
    end
    if (state_q != ST_IDLE) begin
      reg_address = addr_q[1:0];
      mem_address = addr_q;
    end
    if (state_q == ST_DONE) begin
      if (owner_q) begin
        m1_ack   = 1'b1;
        m1_err   = err_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = err_q;
        m0_rdata = rdata_q;
      end
    end
  end

  assign reg_data_in = wdata_q;
  assign mem_data_in = wdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

  logic unused_ok;
  assign unused_ok = last_grant;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter with a small register/memory peripheral model.
module tb_peripheral_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_address = '0, m0_wdata = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_address = '0, m1_wdata = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        reg_read, reg_write, mem_read, mem_write;
  logic [1:0]  reg_address;
  logic [7:0]  mem_address;
  logic [31:0] reg_data_in, mem_data_in;
  logic        reg_read_valid, mem_read_valid;
  logic [31:0] reg_data_out, mem_data_out;
  logic        busy;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  peripheral_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .reg_read(reg_read), .reg_write(reg_write), .reg_address(reg_address),
    .reg_data_in(reg_data_in), .reg_read_valid(reg_read_valid), .reg_data_out(reg_data_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_read_valid(mem_read_valid), .mem_data_out(mem_data_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Peripheral model: read data returned one cycle after the strobe unless withheld.
  logic        hold_valid = 1'b0;
  logic [31:0] regs [4];
  logic [31:0] mem  [256];

  always @(posedge clk) begin
    reg_read_valid <= 1'b0;
    mem_read_valid <= 1'b0;
    if (reset) begin
      for (int k = 0; k < 4; k++) regs[k] <= 32'hCAFE_0000 | 32'(k);
      reg_data_out <= '0;
      mem_data_out <= '0;
    end else begin
      if (reg_write) regs[reg_address] <= reg_data_in;
      if (mem_write) mem[mem_address]  <= mem_data_in;
      if (reg_read && !hold_valid) begin
        reg_read_valid <= 1'b1;
        reg_data_out   <= regs[reg_address];
      end
      if (mem_read && !hold_valid) begin
        mem_read_valid <= 1'b1;
        mem_data_out   <= mem[mem_address];
      end
    end
  end

  // Strobe monitor
  int reg_wr_cnt = 0, reg_rd_cnt = 0, mem_wr_cnt = 0, mem_rd_cnt = 0;
  int overlap_cnt = 0, m0_ack_cnt = 0, m1_ack_cnt = 0;
  logic [31:0] last_reg_wdata = '0;
  logic [7:0]  last_mem_addr = '0;

  always @(negedge clk) begin
    if (reg_write) begin reg_wr_cnt++; last_reg_wdata = reg_data_in; end
    if (reg_read) reg_rd_cnt++;
    if (mem_write) begin mem_wr_cnt++; last_mem_addr = mem_address; end
    if (mem_read) mem_rd_cnt++;
    if ($countones({reg_read, reg_write, mem_read, mem_write}) > 1) overlap_cnt++;
    if (m0_ack) m0_ack_cnt++;
    if (m1_ack) m1_ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one transaction; lat counts edges from the sampling edge to the ack cycle.
  task automatic do_txn(input bit m, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int lat);
    bit got = 1'b0;
    rd = '0; er = 1'b0; lat = 0;
    if (!m) begin m0_write = wr; m0_address = addr; m0_wdata = wd; m0_req = 1'b1; end
    else    begin m1_write = wr; m1_address = addr; m1_wdata = wd; m1_req = 1'b1; end
    for (int c = 1; c <= 60 && !got; c++) begin
      tick();
      if (!m && m0_ack) begin
        got = 1'b1; lat = c; rd = m0_rdata; er = m0_err;
        check("nonowner_ack1", m1_ack, 0);
        check("nonowner_rdata1", m1_rdata, 0);
      end else if (m && m1_ack) begin
        got = 1'b1; lat = c; rd = m1_rdata; er = m1_err;
        check("nonowner_ack0", m0_ack, 0);
        check("nonowner_rdata0", m0_rdata, 0);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("ack_seen", got, 1);
    tick();
  endtask

  initial begin : stimulus
    logic [31:0] rd;
    bit er;
    int lat, n, base_strobes, acks0;
    int order [4];

    // Reset state
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("rst_addr", {reg_address, mem_address}, 0);
    reset = 1'b0;
    tick();

    // m0 writes 67 to register 0
    do_txn(0, 1, 32'd0, 32'd67, rd, er, lat);
    check("wr0_lat", lat, 2);
    check("wr0_err", er, 0);
    check("wr0_strobes", reg_wr_cnt, 1);
    check("wr0_data", last_reg_wdata, 67);

    // m1 reads it back
    do_txn(1, 0, 32'd0, 32'd0, rd, er, lat);
    check("rd0_lat", lat, 3);
    check("rd0_data", rd, 67);
    check("rd0_err", er, 0);

    // Both masters hold requests: grants alternate m0, m1, m0
    m0_write = 1; m0_address = 32'd4; m0_wdata = 32'h11;
    m1_write = 1; m1_address = 32'd8; m1_wdata = 32'h22;
    m0_req = 1; m1_req = 1; n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (m0_ack) begin order[n] = 0; n++; end
      if (m1_ack) begin order[n] = 1; n++; end
    end
    m0_req = 0; m1_req = 0;
    tick();
    check("tie_count", n, 3);
    check("tie_g0", order[0], 0);
    check("tie_g1", order[1], 1);
    check("tie_g2", order[2], 0);
    check("tie_overlap", overlap_cnt, 0);
    check("tie_strobes", reg_wr_cnt, 4);

    // In-window register reads, addr[1:0] ignored
    do_txn(0, 0, 32'd12, 32'd0, rd, er, lat);
    check("rd12_data", rd, 32'hCAFE_0003);
    check("rd12_err", er, 0);
    do_txn(1, 0, 32'd15, 32'd0, rd, er, lat);
    check("rd15_data", rd, 32'hCAFE_0003);
    check("reg_rd_strobes", reg_rd_cnt, 3);

    // Memory round trip
    for (int i = 0; i < 256; i++) begin
      do_txn(0, 1, 32'd1024 + 32'(4 * i), 32'(i), rd, er, lat);
      check("mem_wr_addr", last_mem_addr, 32'(i));
      exp_q.push_back(32'(i));
    end
    check("mem_wr_strobes", mem_wr_cnt, 256);
    for (int i = 0; i < 256; i++) begin
      do_txn(0, 0, 32'd1024 + 32'(4 * i), 32'd0, rd, er, lat);
      check("mem_rd_data", rd, exp_q.pop_front());
      check("mem_rd_err", er, 0);
    end
    do_txn(1, 0, 32'd2047, 32'd0, rd, er, lat);
    check("mem_top_data", rd, 255);

    // Decode errors: no strobe, err=1, rdata=0, ack at k+2
    base_strobes = reg_wr_cnt + reg_rd_cnt + mem_wr_cnt + mem_rd_cnt;
    do_txn(0, 0, 32'd16, 32'd0, rd, er, lat);
    check("err16", {er, rd}, {1'b1, 32'd0});
    check("err16_lat", lat, 2);
    do_txn(1, 0, 32'd4096, 32'd0, rd, er, lat);
    check("err4096", {er, rd}, {1'b1, 32'd0});
    do_txn(0, 0, 32'd1023, 32'd0, rd, er, lat);
    check("err1023", er, 1);
    do_txn(0, 1, 32'd2048, 32'd5, rd, er, lat);
    check("err2048", er, 1);
    check("err_no_strobe", reg_wr_cnt + reg_rd_cnt + mem_wr_cnt + mem_rd_cnt, base_strobes);
    check("final_overlap", overlap_cnt, 0);

`ifdef PERIPH_ARB_TIMEOUT_EN
    // Withheld valid aborts after 4 wait cycles
    hold_valid = 1'b1;
    do_txn(0, 0, 32'd0, 32'd0, rd, er, lat);
    check("timeout_err", {er, rd}, {1'b1, 32'd0});
    check("timeout_lat", lat, 6);
    hold_valid = 1'b0;
`endif

    // Reset asserted while waiting for a withheld read
    hold_valid = 1'b1;
    m0_write = 0; m0_address = 32'd1028; m0_req = 1;
    n = 0;
    for (int c = 0; c < 10 && dbg_state != 2'd2; c++) tick();
    check("reached_wait", dbg_state, 2);
    acks0 = m0_ack_cnt;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_state", dbg_state, 0);
    check("arst_strobes", {reg_read, reg_write, mem_read, mem_write}, 0);
    check("arst_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    check("arst_rdata", m0_rdata | m1_rdata, 0);
    check("arst_addr", {reg_address, mem_address}, 0);
    check("arst_wdata", reg_data_in | mem_data_in, 0);
    m0_req = 0;
    tick();
    reset = 1'b0;
    hold_valid = 1'b0;
    repeat (4) tick();
    check("arst_no_ack", m0_ack_cnt, acks0);

    // Pointer back at m1 after reset: m0 wins the tie
    m0_write = 1; m0_address = 32'd0; m0_wdata = 32'h33;
    m1_write = 1; m1_address = 32'd4; m1_wdata = 32'h44;
    m0_req = 1; m1_req = 1; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      tick();
      if (m0_ack) begin order[n] = 0; n++; m0_req = 0; end
      if (m1_ack) begin order[n] = 1; n++; m1_req = 0; end
    end
    m0_req = 0; m1_req = 0;
    tick();
    check("post_rst_count", n, 2);
    check("post_rst_first", order[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
